fp_divider: RTL and testbench

Sequential single-precision floating-point divider: z = x / y, one quotient bit per clock by restoring division. It is the inverse companion of the shift-add FP multiplier and sits beside it on the CPU's floating-point execute path with the same run/stall handshake. The CPU holds `run` and its operands until `stall` drops, then latches `z`. Denormals are flushed to zero and NaN is not produced; overflow and division by zero yield signed infinity.

---
 rtl/fp_divider.sv | 101 ++++++++++
 tb/tb_fp_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// Sequential single-precision divider: one restoring-division quotient bit per clock,
// with a run/stall handshake. Denormals flush to zero, and overflow or a zero divisor gives signed infinity.
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    localparam logic [4:0] LAST_STEP = 5'd26;
    localparam logic [4:0] DONE_STEP = 5'd27;

    logic [4:0]  step;
    logic [24:0] rem;
    logic [25:0] quo;

    logic        sign;
    logic [7:0]  xe;
    logic [7:0]  ye;
    logic [23:0] mx;
    logic [23:0] my;

    logic [25:0] diff;
    logic        fits;

    logic [23:0]        mant;
    logic               rbit;
    logic [24:0]        mant_rnd;
    logic signed [9:0]  exp_q;

    assign sign = x[31] ^ y[31];
    assign xe   = x[30:23];
    assign ye   = y[30:23];
    assign mx   = {1'b1, x[22:0]};
    assign my   = {1'b1, y[22:0]};

    // diff[25] is the borrow: the divisor does not fit into the partial remainder.
    assign diff = {1'b0, rem} - {2'b00, my};
    assign fits = ~diff[25];

    assign stall = run & (step != DONE_STEP);

    // The step counter saturates at completion so the result is held while run stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step <= 5'd0;
        end else if (!run) begin
            step <= 5'd0;
        end else if (step != DONE_STEP) begin
            step <= step + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem <= 25'd0;
            quo <= 26'd0;
        end else if (step == 5'd0) begin
            rem <= {1'b0, mx};
            quo <= 26'd0;
        end else if (step <= LAST_STEP) begin
            if (fits) begin
                rem <= {diff[23:0], 1'b0};
                quo <= {quo[24:0], 1'b1};
            end else begin
                rem <= {rem[23:0], 1'b0};
                quo <= {quo[24:0], 1'b0};
            end
        end
    end

    // The mantissa ratio lies in (0.5, 2), so the leading one is in quo[25] or quo[24].
    always_comb begin
        mant = quo[24:1];
        rbit = quo[0];
        if (quo[25]) begin
            mant = quo[25:2];
            rbit = quo[1];
        end
        mant_rnd = {1'b0, mant} + {24'd0, rbit};
        exp_q    = $signed({2'b00, xe}) - $signed({2'b00, ye}) + 10'sd127
                 - $signed({9'd0, ~quo[25]}) + $signed({9'd0, mant_rnd[24]});
    end

    always_comb begin
        z = {sign, exp_q[7:0], mant_rnd[22:0]};
        if (xe == 8'd0) begin
            z = 32'd0;
        end else if (ye == 8'd0) begin
            z = {sign, 8'hFF, 23'd0};
        end else if (exp_q >= 10'sd255) begin
            z = {sign, 8'hFF, 23'd0};
        end else if (exp_q <= 10'sd0) begin
            z = 32'd0;
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vectors with literal results, plus an
// arithmetic reference model checked on every cycle.
module tb_fp_divider;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    int errors = 0;
    int checks = 0;
    int elapsed = 0;

    fp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quotient from whole-number division of the scaled mantissas, then normalise, round half-up and check the exponent range.
    function automatic logic [31:0] modelZ(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] q;
        logic [23:0] m;
        logic        rb;
        logic [24:0] m1;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0) return 32'd0;
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        q = ({40'd0, 1'b1, a[22:0]} << 25) / {40'd0, 1'b1, b[22:0]};
        if (q[25]) begin
            m  = q[25:2];
            rb = q[1];
        end else begin
            m  = q[24:1];
            rb = q[0];
        end
        m1 = {1'b0, m} + {24'd0, rb};
        e = int'(a[30:23]) - int'(b[30:23]) + 127 - (q[25] ? 0 : 1) + (m1[24] ? 1 : 0);
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return 32'd0;
        return {s, e[7:0], m1[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycles elapsed since run rose, saturating once the quotient is due.
    always @(posedge clk or negedge rst) begin
        if (!rst) elapsed <= 0;
        else if (!run) elapsed <= 0;
        else if (elapsed < 27) elapsed <= elapsed + 1;
    end

    always @(negedge clk) begin
        checkOutput("stall_cycle", {31'd0, stall}, {31'd0, run && (elapsed < 27)});
        if (rst && run && elapsed == 27)
            checkOutput("z_model", z, modelZ(x, y));
    end

    // Counts stall cycles from the current cycle, then checks the result and that it holds steady.
    task automatic waitResult(input string name, input logic [31:0] expz);
        int n;
        logic [31:0] held;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        checkOutput({name, "_latency"}, 32'(n), 32'd27);
        checkOutput(name, z, expz);
        held = z;
        repeat (2) begin
            @(negedge clk);
            checkOutput({name, "_hold"}, z, held);
        end
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] xv,
                                 input logic [31:0] yv, input logic [31:0] expz);
        x   = xv;
        y   = yv;
        run = 1'b1;
        waitResult(name, expz);
    endtask

    logic [31:0] vec [10][3];

    initial begin
        vec = '{
            '{32'h40C00000, 32'h40000000, 32'h40400000},
            '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB},
            '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB},
            '{32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF},
            '{32'h3F800000, 32'h3F800000, 32'h3F800000},
            '{32'h3F800000, 32'h00000000, 32'h7F800000},
            '{32'h00000000, 32'h40000000, 32'h00000000},
            '{32'h7F000000, 32'h00800000, 32'h7F800000},
            '{32'h00800000, 32'h7F000000, 32'h00000000},
            '{32'h42F60000, 32'h41200000, 32'h4144CCCD}
        };
        rst = 1'b0;
        run = 1'b0;
        x   = 32'd0;
        y   = 32'd0;
        @(negedge clk);
        checkOutput("reset_z", z, 32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++)
            applyStimulus($sformatf("vec%0d", i), vec[i][0], vec[i][1], vec[i][2]);

        // Abort an operation at step 10 and restart it from reset release with run held high.
        x   = 32'h3F800000;
        y   = 32'h40400000;
        run = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        waitResult("after_reset", 32'h3EAAAAAB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
